// File: rtl/fm_pkg.sv
// Shared constants, quadrant encoding and saturation helper for the FM modulator.
package fm_pkg;

  localparam int unsigned LUT_DEPTH = 256;
  localparam int unsigned LUT_W     = 15;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned AUDIO_W   = 16;
  localparam int unsigned IDX_W     = 8;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  // Clamp an 18-bit signed value into the signed 16-bit audio range.
  function automatic logic signed [AUDIO_W-1:0] sat16(input logic signed [AUDIO_W+1:0] v);
    logic signed [AUDIO_W+1:0] max_v;
    logic signed [AUDIO_W+1:0] min_v;
    max_v = 18'sd32767;
    min_v = -18'sd32768;
    if (v > max_v) begin
      return 16'sh7fff;
    end else if (v < min_v) begin
      return 16'sh8000;
    end else begin
      return v[AUDIO_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fm_sine_lut.sv
// Quarter-wave sine ROM, 256 x 15 bits, one registered read cycle.
// Contents are built at elaboration: lut[i] = round(32767 * sin(pi/2 * (i + 0.5) / 256)).
module fm_sine_lut
  import fm_pkg::*;
(
  input  logic             clk_i,
  input  logic [IDX_W-1:0] addr_i,
  output logic [LUT_W-1:0] data_o
);

  localparam int unsigned FracW = 48;
  // pi/2 in Q48 fixed point.
  localparam logic signed [127:0] PiHalfQ = 128'sd442139859501778;

  // Taylor series in wide fixed point keeps the error far below one output LSB.
  function automatic logic [LUT_DEPTH*LUT_W-1:0] gen_rom();
    logic [LUT_DEPTH*LUT_W-1:0] rom;
    logic signed [127:0]        x;
    logic signed [127:0]        x2;
    logic signed [127:0]        term;
    logic signed [127:0]        acc;
    logic signed [127:0]        val;
    rom = '0;
    for (int i = 0; i < int'(LUT_DEPTH); i++) begin
      x    = (PiHalfQ * 128'(2 * i + 1)) / 128'sd512;
      x2   = (x * x) >>> FracW;
      term = x;
      acc  = x;
      for (int k = 1; k <= 10; k++) begin
        term = -((term * x2) >>> FracW) / 128'(2 * k * (2 * k + 1));
        acc  = acc + term;
      end
      val = (acc * 128'sd32767 + (128'sd1 <<< (FracW - 1))) >>> FracW;
      rom[i*LUT_W +: LUT_W] = val[LUT_W-1:0];
    end
    return rom;
  endfunction

  localparam logic [LUT_DEPTH*LUT_W-1:0] Rom = gen_rom();

  logic [LUT_W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    data_q <= Rom[int'(addr_i)*LUT_W +: LUT_W];
  end

  assign data_o = data_q;

endmodule

// File: rtl/fm_modulator.sv
// FM modulator: audio sample -> phase increment -> 32-bit phase accumulator -> sine sample.
// Define FM_PREEMPH_EN to apply first-order pre-emphasis on audio capture.
module fm_modulator
  import fm_pkg::*;
#(
  parameter int unsigned PHASE_W   = 32,
  parameter int unsigned DEV_SHIFT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [AUDIO_W-1:0] audio_in,
  input  logic               audio_valid,
  input  logic [PHASE_W-1:0] carrier_inc,
  input  logic               sample_tick,
  output logic [OUT_W-1:0]   sine_out,
  output logic               sine_valid
);

  // ---------------------------------------------------------------------------
  // Audio capture
  // ---------------------------------------------------------------------------
  logic signed [AUDIO_W-1:0] audio_q, audio_d;

`ifdef FM_PREEMPH_EN
  logic signed [AUDIO_W-1:0] x_prev_q;
  logic signed [AUDIO_W:0]   diff;
  logic signed [AUDIO_W+1:0] emph;

  always_comb begin
    diff    = $signed({audio_in[AUDIO_W-1], audio_in}) - $signed({x_prev_q[AUDIO_W-1], x_prev_q});
    emph    = $signed({audio_in[AUDIO_W-1], audio_in[AUDIO_W-1], audio_in})
            + $signed({diff[AUDIO_W], diff >>> 1});
    audio_d = audio_valid ? sat16(emph) : audio_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_prev_q <= '0;
    end else if (audio_valid) begin
      x_prev_q <= audio_in;
    end
  end
`else
  always_comb begin
    audio_d = audio_valid ? audio_in : audio_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      audio_q <= '0;
    end else begin
      audio_q <= audio_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Increment register and phase accumulator
  // ---------------------------------------------------------------------------
  logic [PHASE_W-1:0] audio_ext, dev;
  logic [PHASE_W-1:0] inc_q, inc_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               adv;

  assign adv = sample_tick & enable;

  always_comb begin
    audio_ext = {{(PHASE_W-AUDIO_W){audio_q[AUDIO_W-1]}}, audio_q};
    dev       = audio_ext << DEV_SHIFT;
    inc_d     = carrier_inc + dev;
    phase_d   = adv ? phase_q + inc_q : phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q   <= '0;
      phase_q <= '0;
    end else begin
      inc_q   <= inc_d;
      phase_q <= phase_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: quadrant / index of the pre-increment phase
  // ---------------------------------------------------------------------------
  logic             s1_valid_q;
  quad_e            s1_quad_q;
  logic [IDX_W-1:0] s1_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_quad_q  <= Q0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= adv;
      if (adv) begin
        s1_quad_q <= quad_e'(phase_q[PHASE_W-1 -: 2]);
        s1_idx_q  <= phase_q[PHASE_W-3 -: IDX_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: mirrored address into the quarter-wave ROM
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lut_addr;
  logic [LUT_W-1:0] lut_data;
  logic             s2_valid_q;
  quad_e            s2_quad_q;

  always_comb begin
    lut_addr = s1_idx_q;
    unique case (s1_quad_q)
      Q0, Q2:  lut_addr = s1_idx_q;
      Q1, Q3:  lut_addr = ~s1_idx_q;  // 255 - idx
      default: lut_addr = s1_idx_q;
    endcase
  end

  fm_sine_lut u_lut (
    .clk_i  (clk),
    .addr_i (lut_addr),
    .data_o (lut_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_quad_q  <= Q0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_quad_q  <= s1_quad_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: sign applied, output registered and held between strobes
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] mag;
  logic [OUT_W-1:0] sine_q, sine_d;
  logic             sine_valid_q;

  always_comb begin
    mag    = {1'b0, lut_data};
    sine_d = sine_q;
    if (s2_valid_q) begin
      unique case (s2_quad_q)
        Q0, Q1:  sine_d = mag;
        Q2, Q3:  sine_d = -mag;
        default: sine_d = mag;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sine_q       <= '0;
      sine_valid_q <= 1'b0;
    end else begin
      sine_q       <= sine_d;
      sine_valid_q <= s2_valid_q;
    end
  end

  assign sine_out   = sine_q;
  assign sine_valid = sine_valid_q;

endmodule

// File: tb/tb_fm_modulator.sv
// Directed, table-driven bench for fm_modulator with a sine reference for the phase sweep.
module tb_fm_modulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] audio_in;
  logic        audio_valid;
  logic [31:0] carrier_inc;
  logic        sample_tick;
  logic [15:0] sine_out;
  logic        sine_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fm_modulator dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .audio_in    (audio_in),
    .audio_valid (audio_valid),
    .carrier_inc (carrier_inc),
    .sample_tick (sample_tick),
    .sine_out    (sine_out),
    .sine_valid  (sine_valid)
  );

  typedef struct {
    logic [31:0] carrier;
    longint      exp_out;
  } vec_t;

  vec_t   vecs[12];
  longint cap_in[5];
  longint cap_exp[5];
  longint sb[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full-circle reference: the quarter-wave mirroring is equivalent to sampling the
  // sine at the centre of each of the 1024 phase bins.
  function automatic longint exp_sine(input logic [31:0] ph);
    real a;
    real v;
    a = 2.0 * 3.14159265358979323846 * (real'(ph[31:22]) + 0.5) / 1024.0;
    v = 32767.0 * $sin(a);
    if (v >= 0.0) return longint'($rtoi(v + 0.5));
    else return -longint'($rtoi(-v + 0.5));
  endfunction

  initial begin
    logic [31:0] m_phase;
    logic [31:0] inc_old;
    logic [31:0] inc_new;
    int          cnt;
    longint      e;

    vecs[0]  = '{32'h4000_0000, 101};
    vecs[1]  = '{32'h4000_0000, 32767};
    vecs[2]  = '{32'h4000_0000, -101};
    vecs[3]  = '{32'h4000_0000, -32767};
    vecs[4]  = '{32'h4000_0000, 101};
    vecs[5]  = '{32'h2000_0000, 32767};
    vecs[6]  = '{32'hE000_0000, 23099};
    vecs[7]  = '{32'h6000_0000, 32767};
    vecs[8]  = '{32'h0000_0000, -23241};
    vecs[9]  = '{32'h6000_0000, -23241};
    vecs[10] = '{32'h2000_0000, 101};
    vecs[11] = '{32'h1234_5678, 23241};

    cap_in = '{1000, 1000, 0, 32767, -32768};
`ifdef FM_PREEMPH_EN
    cap_exp = '{1500, 1000, -500, 32767, -32768};
    inc_new = 32'h00FE_0000;
`else
    cap_exp = '{1000, 1000, 0, 32767, -32768};
    inc_new = 32'h00FF_0000;
`endif
    inc_old = 32'h0101_0000;

    // Reset held with ticks active.
    rst = 1'b1; enable = 1'b1; audio_in = '0; audio_valid = 1'b0;
    carrier_inc = 32'h4000_0000; sample_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_valid", longint'(sine_valid), 0);
      check("rst_out", longint'(sine_out), 0);
    end
    rst = 1'b0; sample_tick = 1'b0;
    step();
    check("rel_valid", longint'(sine_valid), 0);
    check("rel_out", longint'(sine_out), 0);
    check("rel_phase", longint'(dut.phase_q), 0);

    // Carrier-only vectors: one tick per record, exact 3-cycle latency, output held after.
    foreach (vecs[i]) begin
      carrier_inc = vecs[i].carrier;
      step();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
      check($sformatf("vec%0d_early", i), longint'(sine_valid), 0);
      step();
      check($sformatf("vec%0d_valid", i), longint'(sine_valid), 1);
      check($sformatf("vec%0d_out", i), longint'($signed(sine_out)), vecs[i].exp_out);
      step();
      check($sformatf("vec%0d_drop", i), longint'(sine_valid), 0);
      check($sformatf("vec%0d_hold", i), longint'($signed(sine_out)), vecs[i].exp_out);
    end

    // Audio capture, back-to-back strobes from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      audio_in = 16'(cap_in[i]);
      audio_valid = 1'b1;
      step();
      check($sformatf("cap%0d", i), longint'(dut.audio_q), cap_exp[i]);
    end
    audio_valid = 1'b0;

    // Deviation: 0x0100 << 8 on top of the carrier, then a colliding strobe of 0xFF00.
    rst = 1'b1; carrier_inc = 32'h0100_0000; audio_in = 16'h0100;
    step();
    rst = 1'b0; audio_valid = 1'b1;
    step();
    step();
    audio_valid = 1'b0;
    step();
    m_phase = '0;
    sample_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      m_phase += inc_old;
      check($sformatf("dev_step%0d", i), longint'(dut.phase_q), longint'(m_phase));
    end
    audio_in = 16'hFF00; audio_valid = 1'b1;
    step();
    audio_valid = 1'b0;
    m_phase += inc_old;
    check("coll_tick0", longint'(dut.phase_q), longint'(m_phase));
    step();
    m_phase += inc_old;
    check("coll_tick1", longint'(dut.phase_q), longint'(m_phase));
    for (int i = 0; i < 2; i++) begin
      step();
      m_phase += inc_new;
      check($sformatf("coll_new%0d", i), longint'(dut.phase_q), longint'(m_phase));
    end
    sample_tick = 1'b0;

    // Enable gating: one enabled tick, then five ticks with enable low.
    for (int i = 0; i < 4; i++) step();
    sample_tick = 1'b1;
    step();
    m_phase += inc_new;
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) sample_tick = 1'b0;
      step();
      if (sine_valid) cnt++;
    end
    check("gate_phase", longint'(dut.phase_q), longint'(m_phase));
    check("gate_valids", cnt, 1);
    enable = 1'b1;

    // Full-throughput sweep of all 1024 phase bins against the sine reference.
    rst = 1'b1; carrier_inc = 32'h0040_0000; audio_in = '0;
    step();
    rst = 1'b0;
    step();
    m_phase = '0;
    for (int t = 0; t < 1030; t++) begin
      sample_tick = (t < 1024);
      step();
      if (t < 1024) begin
        sb.push_back(exp_sine(m_phase));
        m_phase += 32'h0040_0000;
      end
      if (sine_valid) begin
        if (sb.size() == 0) begin
          check("sweep_extra", 1, 0);
        end else begin
          e = sb.pop_front();
          check($sformatf("sweep%0d", t), longint'($signed(sine_out)), e);
        end
      end
    end
    check("sweep_left", longint'(sb.size()), 0);

    // Reset with samples in flight.
    sample_tick = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    check("midrst_valid", longint'(sine_valid), 0);
    rst = 1'b0; sample_tick = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (sine_valid) cnt++;
    end
    check("midrst_flush", cnt, 0);
    check("midrst_phase", longint'(dut.phase_q), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
